// File: rtl/vector_shift_unit.sv
// Two-stage valid/ready per-element vector shifter (SRL/SRA/SLL, SEW 8/16/32/64).
// Optional rounding right shifts with extra port round_i when VSHIFT_ROUND_EN is defined.
module vector_shift_unit #(
  parameter int DATA_W = 128,
  parameter int TAG_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        vsew_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [TAG_W-1:0]  tag_i,
`ifdef VSHIFT_ROUND_EN
  input  logic              round_i,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] s_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              err_o
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;

  // One element held in the low SEW bits of a 64-bit container; result is masked back to SEW.
  function automatic logic [63:0] elem_shift(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] sew, input logic [1:0] op,
                                             input logic rnd);
    logic [6:0]  width;
    logic [5:0]  msb;
    logic [5:0]  sh;
    logic [63:0] mask;
    logic [63:0] ext;
    logic [63:0] res;
    logic        rbit;
    width = 7'd8 << sew;
    msb   = 6'(width - 7'd1);
    mask  = {64{1'b1}} >> (7'd64 - width);
    sh    = 6'(b & {58'd0, msb});
    ext   = (op == OP_SRA && a[msb]) ? (a | ~mask) : (a & mask);
    case (op)
      OP_SRL:  res = ext >> sh;
      OP_SRA:  res = $unsigned($signed(ext) >>> sh);
      OP_SLL:  res = ext << sh;
      default: res = 64'd0;
    endcase
    rbit = (rnd && op != OP_SLL && sh != 6'd0) ? ext[sh - 6'd1] : 1'b0;
    return (res + {63'd0, rbit}) & mask;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [2:0]        s1_vsew_q, s1_vsew_d;
  logic [1:0]        s1_op_q, s1_op_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_s_q, s2_s_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
  logic              s2_err_q, s2_err_d;
  logic              s1_adv_s, s2_adv_s, rnd_s, err_s;
  logic [DATA_W-1:0] r8_s, r16_s, r32_s, r64_s, res_s;

`ifdef VSHIFT_ROUND_EN
  logic s1_round_q, s1_round_d;
  assign rnd_s = s1_round_q;
`else
  assign rnd_s = 1'b0;
`endif

  assign s2_adv_s    = ~s2_valid_q | out_ready_i;
  assign s1_adv_s    = ~s1_valid_q | s2_adv_s;
  assign in_ready_o  = s1_adv_s;
  assign out_valid_o = s2_valid_q;
  assign s_o         = s2_s_q;
  assign tag_o       = s2_tag_q;
  assign err_o       = s2_err_q;

  always_comb begin
    r8_s  = {DATA_W{1'b0}};
    r16_s = {DATA_W{1'b0}};
    r32_s = {DATA_W{1'b0}};
    r64_s = {DATA_W{1'b0}};
    for (int k = 0; k < DATA_W / 8; k++)
      r8_s[k*8 +: 8] = 8'(elem_shift({56'd0, s1_a_q[k*8 +: 8]}, {56'd0, s1_b_q[k*8 +: 8]},
                                     2'd0, s1_op_q, rnd_s));
    for (int k = 0; k < DATA_W / 16; k++)
      r16_s[k*16 +: 16] = 16'(elem_shift({48'd0, s1_a_q[k*16 +: 16]}, {48'd0, s1_b_q[k*16 +: 16]},
                                         2'd1, s1_op_q, rnd_s));
    for (int k = 0; k < DATA_W / 32; k++)
      r32_s[k*32 +: 32] = 32'(elem_shift({32'd0, s1_a_q[k*32 +: 32]}, {32'd0, s1_b_q[k*32 +: 32]},
                                         2'd2, s1_op_q, rnd_s));
    for (int k = 0; k < DATA_W / 64; k++)
      r64_s[k*64 +: 64] = elem_shift(s1_a_q[k*64 +: 64], s1_b_q[k*64 +: 64],
                                     2'd3, s1_op_q, rnd_s);
  end

  // Illegal encodings still occupy a slot but return a zero result with err set.
  always_comb begin
    err_s = s1_vsew_q[2] | (s1_op_q == 2'b11);
    case (s1_vsew_q)
      3'b000:  res_s = r8_s;
      3'b001:  res_s = r16_s;
      3'b010:  res_s = r32_s;
      3'b011:  res_s = r64_s;
      default: res_s = {DATA_W{1'b0}};
    endcase
    if (err_s) res_s = {DATA_W{1'b0}};
    else       res_s = res_s;
  end

  always_comb begin
    if (s1_adv_s) s1_valid_d = in_valid_i;
    else          s1_valid_d = s1_valid_q;
    if (s1_adv_s && in_valid_i) begin
      s1_vsew_d = vsew_i;
      s1_op_d   = op_i;
      s1_a_d    = a_i;
      s1_b_d    = b_i;
      s1_tag_d  = tag_i;
    end else begin
      s1_vsew_d = s1_vsew_q;
      s1_op_d   = s1_op_q;
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s1_tag_d  = s1_tag_q;
    end
`ifdef VSHIFT_ROUND_EN
    if (s1_adv_s && in_valid_i) s1_round_d = round_i;
    else                        s1_round_d = s1_round_q;
`endif
    if (s2_adv_s) s2_valid_d = s1_valid_q;
    else          s2_valid_d = s2_valid_q;
    if (s2_adv_s && s1_valid_q) begin
      s2_s_d   = res_s;
      s2_tag_d = s1_tag_q;
      s2_err_d = err_s;
    end else begin
      s2_s_d   = s2_s_q;
      s2_tag_d = s2_tag_q;
      s2_err_d = s2_err_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_vsew_q  <= 3'd0;
      s1_op_q    <= 2'd0;
      s1_a_q     <= {DATA_W{1'b0}};
      s1_b_q     <= {DATA_W{1'b0}};
      s1_tag_q   <= {TAG_W{1'b0}};
      s2_valid_q <= 1'b0;
      s2_s_q     <= {DATA_W{1'b0}};
      s2_tag_q   <= {TAG_W{1'b0}};
      s2_err_q   <= 1'b0;
`ifdef VSHIFT_ROUND_EN
      s1_round_q <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_vsew_q  <= s1_vsew_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_s_q     <= s2_s_d;
      s2_tag_q   <= s2_tag_d;
      s2_err_q   <= s2_err_d;
`ifdef VSHIFT_ROUND_EN
      s1_round_q <= s1_round_d;
`endif
    end
  end

endmodule

// File: tb/tb_vector_shift_unit.sv
// Randomized self-checking bench for vector_shift_unit: queue-based reference model,
// per-cycle output comparison, plus literal pins of the model and directed corner cases.
module tb_vector_shift_unit;
  localparam int DATA_W = 128;
  localparam int TAG_W  = 4;
`ifdef VSHIFT_ROUND_EN
  localparam bit ROUND_ON = 1'b1;
`else
  localparam bit ROUND_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              iv, ordy, rn;
  logic [2:0]        vs;
  logic [1:0]        op;
  logic [DATA_W-1:0] a, b;
  logic [TAG_W-1:0]  tg;
  logic              in_ready_o, out_valid_o, err_o;
  logic [DATA_W-1:0] s_o;
  logic [TAG_W-1:0]  tag_o;

  always #5 clk = ~clk;

  vector_shift_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(in_ready_o),
    .vsew_i(vs), .op_i(op), .a_i(a), .b_i(b), .tag_i(tg),
`ifdef VSHIFT_ROUND_EN
    .round_i(rn),
`endif
    .out_valid_o(out_valid_o), .out_ready_i(ordy), .s_o(s_o), .tag_o(tag_o), .err_o(err_o)
  );

  typedef struct {
    logic [DATA_W-1:0] s;
    logic              err;
    logic [TAG_W-1:0]  tag;
    int                edge_n;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0, edge_cnt = 0, pops = 0;
  logic last_push = 1'b0;

  // Reference: returns {err, s}. Elements handled as plain unsigned integers.
  function automatic logic [DATA_W:0] ref_model(input logic [2:0] vsew, input logic [1:0] opc,
                                                input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv,
                                                input logic rnd);
    longint unsigned   sew, mask, e, sh, r;
    longint            se;
    logic [DATA_W-1:0] s, t;
    if (vsew > 3'd3 || opc == 2'b11) return {1'b1, {DATA_W{1'b0}}};
    sew  = 64'd8 << vsew;
    mask = (sew == 64'd64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
    s    = '0;
    for (int k = 0; k < DATA_W / int'(sew); k++) begin
      t  = av >> (k * int'(sew));
      e  = t[63:0] & mask;
      t  = bv >> (k * int'(sew));
      sh = t[63:0] % sew;
      case (opc)
        2'b00: r = e >> sh;
        2'b01: begin
          se = ((e >> (sew - 64'd1)) & 64'd1) != 64'd0 ? longint'(e | ~mask) : longint'(e);
          r  = longint'(se >>> sh);
        end
        default: r = e << sh;
      endcase
      if (rnd && opc != 2'b10 && sh != 64'd0) r = r + ((e >> (sh - 64'd1)) & 64'd1);
      r = r & mask;
      t = DATA_W'(r);
      s = s | (t << (k * int'(sew)));
    end
    return {1'b0, s};
  endfunction

  task automatic chk(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_v;
    exp_v = (q.size() > 0) && (q[0].edge_n < edge_cnt);
    chk("out_valid", out_valid_o, exp_v);
    if (exp_v && out_valid_o) begin
      chk("s_o", s_o, q[0].s);
      chk("tag_o", tag_o, q[0].tag);
      chk("err_o", err_o, q[0].err);
    end
  endtask

  // Inputs are set at a negedge; this advances one clock and checks the new outputs.
  task automatic tick();
    logic              push, pop;
    logic [DATA_W:0]   m;
    exp_t              e;
    #1;
    chk("in_ready", in_ready_o, (q.size() < 2) || ordy);
    push = iv && in_ready_o;
    pop  = out_valid_o && ordy;
    m    = ref_model(vs, op, a, b, ROUND_ON && rn);
    @(posedge clk);
    edge_cnt++;
    if (pop && q.size() > 0) begin
      q.delete(0);
      pops++;
    end
    if (push) begin
      e.s = m[DATA_W-1:0]; e.err = m[DATA_W]; e.tag = tg; e.edge_n = edge_cnt;
      q.push_back(e);
    end
    last_push = push;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_payload();
    vs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    for (int j = 0; j < DATA_W / 32; j++) begin
      a[j*32 +: 32] = $urandom;
      b[j*32 +: 32] = $urandom;
    end
    if ($urandom_range(0, 5) == 0) b = '0;
    tg = 4'($urandom);
    rn = 1'($urandom);
  endtask

  task automatic drive_op(input logic [2:0] v, input logic [1:0] o, input logic [DATA_W-1:0] pa,
                          input logic [DATA_W-1:0] pb, input logic [TAG_W-1:0] t, input logic r);
    logic acc;
    vs = v; op = o; a = pa; b = pb; tg = t; rn = r; iv = 1'b1; acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      ordy = ($urandom_range(0, 2) != 0);
      tick();
      acc = last_push;
    end
    chk("accept_bound", acc, 1'b1);
    iv = 1'b0;
  endtask

  task automatic drain();
    iv = 1'b0; ordy = 1'b1;
    for (int n = 0; n < 10 && q.size() > 0; n++) tick();
    chk("drain_empty", q.size() == 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W:0]   m;
    logic [DATA_W-1:0] pa[5], pb[5];
    int                idx, pops0;
    rst = 1'b1; iv = 1'b0; ordy = 1'b0; rn = 1'b0; vs = '0; op = '0; a = '0; b = '0; tg = '0;
    #1;
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_s_o", s_o, '0);
    chk("rst_tag_o", tag_o, '0);
    chk("rst_err_o", err_o, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", in_ready_o, 1'b1);
    @(negedge clk);

    // Literal pins on the model itself
    m = ref_model(3'b000, 2'b01, {16{8'h80}}, {16{8'h0B}}, 1'b0); chk("pin_sra8", m, {1'b0, {16{8'hF0}}});
    m = ref_model(3'b000, 2'b00, {16{8'h80}}, {16{8'h0B}}, 1'b0); chk("pin_srl8", m, {1'b0, {16{8'h10}}});
    m = ref_model(3'b000, 2'b00, {16{8'h80}}, {16{8'hF9}}, 1'b0); chk("pin_srl8_hi", m, {1'b0, {16{8'h40}}});
    m = ref_model(3'b011, 2'b10, {64'h5, 64'h1}, {64'h41, 64'h7F}, 1'b0);
    chk("pin_sll64", m, {1'b0, 64'hA, 64'h8000_0000_0000_0000});
    m = ref_model(3'b001, 2'b01, {8{16'h8001}}, {8{16'h001F}}, 1'b0); chk("pin_sra16", m, {1'b0, {8{16'hFFFF}}});
    m = ref_model(3'b101, 2'b00, {16{8'h80}}, '0, 1'b0); chk("pin_bad_vsew", m, {1'b1, {DATA_W{1'b0}}});
    m = ref_model(3'b000, 2'b11, {16{8'h80}}, '0, 1'b0); chk("pin_bad_op", m, {1'b1, {DATA_W{1'b0}}});
    m = ref_model(3'b010, 2'b00, {4{32'hB}}, {4{32'h2}}, 1'b1); chk("pin_rnd1", m, {1'b0, {4{32'h3}}});
    m = ref_model(3'b010, 2'b00, {4{32'hB}}, {4{32'h2}}, 1'b0); chk("pin_rnd0", m, {1'b0, {4{32'h2}}});
    m = ref_model(3'b010, 2'b00, {4{32'hB}}, '0, 1'b1); chk("pin_rnd_sh0", m, {1'b0, {4{32'hB}}});

    // Directed corner cases through the DUT
    drive_op(3'b000, 2'b01, {16{8'h80}}, {16{8'h0B}}, 4'h1, 1'b0);
    drive_op(3'b000, 2'b00, {16{8'h80}}, {16{8'h0B}}, 4'h2, 1'b0);
    drive_op(3'b011, 2'b10, {64'h5, 64'h1}, {64'h41, 64'h7F}, 4'h3, 1'b0);
    drive_op(3'b101, 2'b00, {16{8'h80}}, {16{8'h01}}, 4'hA, 1'b0);
    drive_op(3'b000, 2'b11, {16{8'h80}}, {16{8'h01}}, 4'hA, 1'b0);
    drive_op(3'b010, 2'b00, {4{32'hB}}, {4{32'h2}}, 4'h4, 1'b1);
    drive_op(3'b010, 2'b00, {4{32'hB}}, {4{32'h2}}, 4'h5, 1'b0);
    drive_op(3'b010, 2'b00, {4{32'hB}}, '0, 4'h6, 1'b1);
    drain();

    // Backpressure: five back-to-back ops, consumer stalled for four cycles
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      pa[i] = a; pb[i] = b;
    end
    idx = 0; pops0 = pops; last_push = 1'b0; iv = 1'b0;
    for (int c = 0; c < 40 && (idx < 5 || q.size() > 0); c++) begin
      if (iv && last_push) idx++;
      if (c == 4) begin
        chk("bp_accepts", idx, 2);
        chk("bp_in_ready_low", in_ready_o, 1'b0);
      end
      iv = (idx < 5);
      if (iv) begin
        a = pa[idx]; b = pb[idx]; tg = 4'(idx + 1); vs = 3'b010; op = 2'b01; rn = 1'b0;
      end
      ordy = (c >= 4);
      tick();
    end
    chk("bp_pops", pops - pops0, 5);
    drain();

    // Random traffic
    iv = 1'b0; last_push = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!(iv && !last_push)) begin
        iv = ($urandom_range(0, 3) != 0);
        if (iv) rand_payload();
      end
      ordy = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset with two ops in flight
    ordy = 1'b0; iv = 1'b1;
    rand_payload(); tick();
    rand_payload(); tick();
    chk("pre_rst_valid", out_valid_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid_o, 1'b0);
    chk("async_rst_s", s_o, '0);
    chk("async_rst_tag", tag_o, '0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; iv = 1'b0; last_push = 1'b0;
    q.delete();
    #1 chk("post_rst_ready", in_ready_o, 1'b1);
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
